spi_host_master: RTL and testbench

- SPI host-side master for the MiST/Calypso control link. It drives the same wires the core samples: SCK, MOSI, and three active-low selects (user_io, data_io, OSD). It also captures MISO.
- Issues framed transfers: one command byte, then N payload bytes.
- Used as the controller end in self-test and bench harnesses. Also used by on-FPGA soft controllers that feed user_io/data_io without the external MCU.

---
 rtl/spi_host_master.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_host_master.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_master.sv
// spi_host_master: SPI mode-0 host for the MiST control link; frames are one command byte plus len payload bytes.
// Optional FETCH stall timeout: define SPIM_STALL_TIMEOUT_EN.
module spi_host_master #(
    parameter int CLK_DIV = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] target,
    input  logic [7:0] cmd,
    input  logic [7:0] len,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_is_cmd,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       ss_user_n,
    output logic       ss_data_n,
    output logic       ss_osd_n
);

    // state | meaning
    // IDLE  | waiting for start with a legal target
    // SETUP | select low, SCK low, first MOSI bit presented
    // SHIFT | eight SCK periods of the current byte
    // FETCH | tx_ready high, waiting for the next payload byte
    // HOLD  | SCK low before the select is released
    // GAP   | select high before done
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_FETCH, S_HOLD, S_GAP} state_t;

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_remain;
    logic [6:0]       r_tx_sh;
    logic             r_sck;
    logic             r_mosi;
    logic [2:0]       r_ss_n;
    logic             r_busy;
    logic             r_done;
    logic             r_tx_ready;
    logic             r_byte_cmd;
    logic             r_rise;

    logic             r_miso_s1;
    logic             r_miso_s2;
    logic             r_rise_d;
    logic [6:0]       r_rx_sh;
    logic [2:0]       r_rx_cnt;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_rx_is_cmd;

`ifdef SPIM_STALL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] r_stall;
    logic             r_tmo;
    logic             r_err;
`else
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_remain   <= '0;
            r_tx_sh    <= '0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_ss_n     <= 3'b111;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_byte_cmd <= 1'b0;
            r_rise     <= 1'b0;
`ifdef SPIM_STALL_TIMEOUT_EN
            r_stall    <= '0;
            r_tmo      <= 1'b0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_rise <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && target != 2'd3) begin
                        r_state    <= S_SETUP;
                        r_cnt      <= DIV_LAST;
                        r_busy     <= 1'b1;
                        r_ss_n     <= ~(3'b001 << target);
                        r_tx_sh    <= cmd[6:0];
                        r_mosi     <= cmd[7];
                        r_bit      <= '0;
                        r_remain   <= len;
                        r_byte_cmd <= 1'b1;
`ifdef SPIM_STALL_TIMEOUT_EN
                        r_tmo      <= 1'b0;
                        r_err      <= 1'b0;
`endif
                    end
                end
                S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= DIV_LAST;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_cnt <= DIV_LAST;
                        if (!r_sck) begin
                            r_sck  <= 1'b1;
                            r_rise <= 1'b1;
                        end else begin
                            r_sck <= 1'b0;
                            if (r_bit == 3'd7) begin
                                if (r_remain != 8'd0) begin
                                    r_state    <= S_FETCH;
                                    r_tx_ready <= 1'b1;
`ifdef SPIM_STALL_TIMEOUT_EN
                                    r_stall    <= '0;
`endif
                                end else begin
                                    r_state <= S_HOLD;
                                end
                            end else begin
                                r_bit   <= r_bit + 3'd1;
                                r_mosi  <= r_tx_sh[6];
                                r_tx_sh <= {r_tx_sh[5:0], 1'b0};
                            end
                        end
                    end
                end
                S_FETCH: begin
                    if (tx_valid) begin
                        r_state    <= S_SHIFT;
                        r_tx_ready <= 1'b0;
                        r_cnt      <= DIV_LAST;
                        r_bit      <= '0;
                        r_tx_sh    <= tx_data[6:0];
                        r_mosi     <= tx_data[7];
                        r_remain   <= r_remain - 8'd1;
                        r_byte_cmd <= 1'b0;
                    end
`ifdef SPIM_STALL_TIMEOUT_EN
                    else if (r_stall == TMO_W'(TIMEOUT - 1)) begin
                        r_state    <= S_HOLD;
                        r_tx_ready <= 1'b0;
                        r_cnt      <= DIV_LAST;
                        r_tmo      <= 1'b1;
                    end else begin
                        r_stall <= r_stall + 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= S_GAP;
                        r_ss_n  <= 3'b111;
                        r_cnt   <= DIV_LAST;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`ifdef SPIM_STALL_TIMEOUT_EN
                        r_err   <= r_tmo;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sampling runs two cycles behind the SCK rise so the synchroniser latency is
    // cancelled: the captured bit is the MISO level present at the rising edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_miso_s1   <= 1'b0;
            r_miso_s2   <= 1'b0;
            r_rise_d    <= 1'b0;
            r_rx_sh     <= '0;
            r_rx_cnt    <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_is_cmd <= 1'b0;
        end else begin
            r_miso_s1  <= spi_miso;
            r_miso_s2  <= r_miso_s1;
            r_rise_d   <= r_rise;
            r_rx_valid <= 1'b0;
            if (r_rise_d) begin
                r_rx_sh  <= {r_rx_sh[5:0], r_miso_s2};
                r_rx_cnt <= r_rx_cnt + 3'd1;
                if (r_rx_cnt == 3'd7) begin
                    r_rx_data   <= {r_rx_sh, r_miso_s2};
                    r_rx_valid  <= 1'b1;
                    r_rx_is_cmd <= r_byte_cmd;
                end
            end
        end
    end

    assign tx_ready  = r_tx_ready;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign rx_is_cmd = r_rx_is_cmd;
    assign busy      = r_busy;
    assign done      = r_done;
    assign spi_sck   = r_sck;
    assign spi_mosi  = r_mosi;
    assign ss_user_n = r_ss_n[0];
    assign ss_data_n = r_ss_n[1];
    assign ss_osd_n  = r_ss_n[2];
`ifdef SPIM_STALL_TIMEOUT_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master: a frame-level model predicts MOSI bits, received bytes and select time;
// a negedge monitor compares the DUT against it every cycle of a frame.
module tb_spi_host_master;

    localparam int CLK_DIV = 2;
    localparam int TIMEOUT = 16;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] target = 2'd0;
    logic [7:0] cmd = 8'h00;
    logic [7:0] len = 8'h00;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, rx_valid, rx_is_cmd, busy, done, err;
    logic [7:0] rx_data;
    logic       spi_sck, spi_mosi, spi_miso;
    logic       ss_user_n, ss_data_n, ss_osd_n;

    logic loop_en = 1'b1;
    logic miso_const = 1'b0;
    assign spi_miso = loop_en ? spi_mosi : miso_const;

    spi_host_master #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .target(target),
        .cmd(cmd), .len(len), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_is_cmd(rx_is_cmd), .busy(busy), .done(done), .err(err),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .ss_user_n(ss_user_n), .ss_data_n(ss_data_n), .ss_osd_n(ss_osd_n)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s", name);
    endfunction

    // Frame model
    bit         q_bits[$];
    logic [8:0] q_rx[$];
    logic [7:0] pay [0:7];
    logic [2:0] exp_sel = 3'b000;
    bit         mon_on = 1'b0;
    bit         exp_err = 1'b0;
    int         exp_sel_len = 0;
    int         sel_cnt = 0;
    int         rise_cnt = 0;
    int         frames_done = 0;
    logic [7:0] last_rx = 8'h00;
    logic       last_rx_cmd = 1'b0;
    logic       prev_sck = 1'b0;
    logic       prev_mosi = 1'b0;

    always @(negedge clk_sys) begin
        logic [2:0] ss_n;
        logic       sel_low;
        logic [8:0] e;
        ss_n    = {ss_osd_n, ss_data_n, ss_user_n};
        sel_low = ((~ss_n) & exp_sel) != 3'b000;
        if (mon_on) begin
            check("ss_other", ss_n | exp_sel, 3'b111);
            if (sel_low) begin
                sel_cnt++;
                check("busy_frame", busy, 1'b1);
            end
            if (spi_sck) check("sck_needs_ss", sel_low, 1'b1);
            if (tx_ready) begin
                check("fetch_sck_low", spi_sck, 1'b0);
                check("fetch_ss_low", sel_low, 1'b1);
            end
            if (prev_sck && spi_sck) check("mosi_stable", spi_mosi, prev_mosi);
            if (spi_sck && !prev_sck) begin
                rise_cnt++;
                if (q_bits.size() == 0) fail_now("extra_sck_rise");
                else check("mosi_bit", spi_mosi, q_bits.pop_front());
            end
            if (rx_valid) begin
                last_rx     = rx_data;
                last_rx_cmd = rx_is_cmd;
                if (q_rx.size() == 0) fail_now("extra_rx_valid");
                else begin
                    e = q_rx.pop_front();
                    check("rx_data", rx_data, e[7:0]);
                    check("rx_is_cmd", rx_is_cmd, e[8]);
                end
            end
            if (done) begin
                check("sel_len", sel_cnt, exp_sel_len);
                check("bits_left", q_bits.size(), 0);
                check("rx_left", q_rx.size(), 0);
                check("err_at_done", err, exp_err);
                check("busy_at_done", busy, 1'b0);
                frames_done++;
            end
        end
        prev_sck  = spi_sck;
        prev_mosi = spi_mosi;
    end

    task automatic push_byte(input logic [7:0] b, input bit is_cmd);
        for (int k = 7; k >= 0; k--) q_bits.push_back(b[k]);
        if (loop_en) q_rx.push_back({is_cmd, b});
        else         q_rx.push_back({is_cmd, {8{miso_const}}});
    endtask

    task automatic run_frame(input logic [1:0] tgt, input logic [7:0] c, input int n,
                             input int stall_idx, input int stall_len, input bit tmo);
        int fd;
        int guard;
        q_bits.delete();
        q_rx.delete();
        push_byte(c, 1'b1);
        if (!tmo) for (int i = 0; i < n; i++) push_byte(pay[i], 1'b0);
        exp_sel     = 3'b001 << tgt;
        exp_err     = tmo;
        exp_sel_len = tmo ? (2 * CLK_DIV + 16 * CLK_DIV + TIMEOUT)
                          : (2 * CLK_DIV + (n + 1) * 16 * CLK_DIV + n + stall_len);
        sel_cnt  = 0;
        rise_cnt = 0;
        fd       = frames_done;
        @(negedge clk_sys);
        target = tgt; cmd = c; len = n[7:0]; start = 1'b1; mon_on = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        for (int i = 0; i < n && !tmo; i++) begin
            tx_data = pay[i];
            if (i != stall_idx) tx_valid = 1'b1;
            guard = 0;
            while (!tx_ready && guard < 2000) begin
                @(negedge clk_sys);
                guard++;
            end
            if (guard >= 2000) begin
                fail_now("tx_ready_timeout");
                break;
            end
            if (i == stall_idx) begin
                repeat (stall_len) @(negedge clk_sys);
                tx_valid = 1'b1;
            end
            @(negedge clk_sys);
            tx_valid = 1'b0;
        end
        guard = 0;
        while (frames_done == fd && guard < 3000) begin
            @(negedge clk_sys);
            guard++;
        end
        if (frames_done == fd) fail_now("done_timeout");
        @(negedge clk_sys);
        mon_on = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        repeat (3) @(negedge clk_sys);
        check("rst_ss", {ss_osd_n, ss_data_n, ss_user_n}, 3'b111);
        check("rst_sck", spi_sck, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rxv", rx_valid, 1'b0);
        check("rst_rxcmd", rx_is_cmd, 1'b0);
        check("rst_txr", tx_ready, 1'b0);
        check("rst_rxd", rx_data, 8'h00);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // command-only frame, MISO looped back from MOSI
        loop_en = 1'b1;
        run_frame(2'd0, 8'h14, 0, -1, 0, 1'b0);
        check("A_sel_cycles", sel_cnt, 36);
        check("A_rises", rise_cnt, 8);
        check("A_rx", last_rx, 8'h14);
        check("A_rx_cmd", last_rx_cmd, 1'b1);

        // data_io frame, payload ready at once, MISO held high
        loop_en = 1'b0; miso_const = 1'b1;
        pay[0] = 8'h12; pay[1] = 8'h34;
        run_frame(2'd1, 8'h55, 2, -1, 0, 1'b0);
        check("B_sel_cycles", sel_cnt, 102);
        check("B_rises", rise_cnt, 24);
        check("B_rx", last_rx, 8'hFF);

        // OSD frame with a 50-cycle stall before payload byte 1
        loop_en = 1'b1;
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        run_frame(2'd2, 8'h3C, 3, 1, 50, 1'b0);
        check("S_sel_cycles", sel_cnt, 185);
        check("S_rises", rise_cnt, 32);
        check("S_rx", last_rx, 8'hC3);

        // start while busy (target 1 and target 3) must not disturb the frame
        pay[0] = 8'h7E;
        fork
            run_frame(2'd0, 8'h81, 1, -1, 0, 1'b0);
            begin
                repeat (20) @(negedge clk_sys);
                target = 2'd1; cmd = 8'hFF; len = 8'd5; start = 1'b1;
                @(negedge clk_sys);
                start = 1'b0;
                repeat (10) @(negedge clk_sys);
                target = 2'd3; start = 1'b1;
                @(negedge clk_sys);
                start = 1'b0;
            end
        join
        check("I_sel_cycles", sel_cnt, 69);
        check("I_rx", last_rx, 8'h7E);

        // reserved target from IDLE is ignored
        @(negedge clk_sys);
        target = 2'd3; cmd = 8'h42; len = 8'd0; start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        repeat (40) begin
            check("t3_busy", busy, 1'b0);
            check("t3_done", done, 1'b0);
            check("t3_ss", {ss_osd_n, ss_data_n, ss_user_n}, 3'b111);
            @(negedge clk_sys);
        end

        // reset in the middle of SHIFT
        target = 2'd0; cmd = 8'hA5; len = 8'd0; start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        repeat (8) @(negedge clk_sys);
        guard = 0;
        while (!spi_sck && guard < 100) begin
            @(negedge clk_sys);
            guard++;
        end
        check("mid_sck_high", spi_sck, 1'b1);
        check("mid_ss_low", ss_user_n, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check("arst_ss", {ss_osd_n, ss_data_n, ss_user_n}, 3'b111);
        check("arst_sck", spi_sck, 1'b0);
        check("arst_busy", busy, 1'b0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (60) begin
            check("post_rst_busy", busy, 1'b0);
            check("post_rst_done", done, 1'b0);
            @(negedge clk_sys);
        end

`ifdef SPIM_STALL_TIMEOUT_EN
        run_frame(2'd0, 8'h9A, 1, -1, 0, 1'b1);
        check("T_sel_cycles", sel_cnt, 52);
        check("T_err_sticky", err, 1'b1);
        check("T_ss_high", ss_user_n, 1'b1);
`endif

        // normal frame after reset recovers (and clears any earlier err)
        loop_en = 1'b1;
        pay[0] = 8'h5A;
        run_frame(2'd1, 8'hC3, 1, -1, 0, 1'b0);
        check("R_sel_cycles", sel_cnt, 69);
        check("R_rx", last_rx, 8'h5A);
        check("R_err", err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
